// File: rtl/fifo_ctrl_1r1w.sv
// rtl/fifo_ctrl_1r1w.sv - single-clock ready/valid FIFO controller for an external 1R1W RAM
//
// Sequences a RAM with synchronous write and asynchronous read as a queue.
// Owns the read/write pointers, the full/empty flags and the occupancy count.
// There is no fall-through: a word written at edge N appears on data_o after N.
//
// Ports:
//   clk_i           clock, all state updates on posedge
//   reset_i         synchronous active-high reset, empties the queue
//   flush_i         synchronous clear of queue contents (below reset in priority)
//   valid_i/data_i  producer side, handshake with ready_o
//   ready_o         !full, state-only
//   valid_o/data_o  consumer side, handshake with ready_i; data_o is ram_rd_data_i
//   ready_i         consumer takes the head word
//   count_o         occupancy 0..depth_p
//   ram_wr_*        RAM write port (enable, address, data)
//   ram_rd_addr_o   RAM read address (head of queue)
//   ram_rd_data_i   RAM asynchronous read data

module fifo_ctrl_1r1w #(
    parameter int width_p = 8,
    parameter int depth_p = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       flush_i,
    input  logic                       valid_i,
    input  logic [width_p-1:0]         data_i,
    output logic                       ready_o,
    output logic                       valid_o,
    output logic [width_p-1:0]         data_o,
    input  logic                       ready_i,
    output logic [$clog2(depth_p):0]   count_o,
    output logic                       ram_wr_valid_o,
    output logic [$clog2(depth_p)-1:0] ram_wr_addr_o,
    output logic [width_p-1:0]         ram_wr_data_o,
    output logic [$clog2(depth_p)-1:0] ram_rd_addr_o,
    input  logic [width_p-1:0]         ram_rd_data_i
);

    localparam int addr_w_lp = $clog2(depth_p);
    localparam int ptr_w_lp  = addr_w_lp + 1;
    localparam logic [ptr_w_lp-1:0] ptr_one_lp = ptr_w_lp'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // when the address bits coincide.
    logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d;
    logic [ptr_w_lp-1:0] rd_ptr_q, rd_ptr_d;
    logic                empty;
    logic                full;
    logic                push;
    logic                pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[addr_w_lp-1:0] == rd_ptr_q[addr_w_lp-1:0])
                && (wr_ptr_q[addr_w_lp] != rd_ptr_q[addr_w_lp]);

    // Flags come from registered state only, so no input-to-handshake path.
    assign ready_o = ~full;
    assign valid_o = ~empty;

    assign push = valid_i & ready_o & ~reset_i & ~flush_i;
    assign pop  = valid_o & ready_i & ~reset_i & ~flush_i;

    assign count_o = wr_ptr_q - rd_ptr_q;

    assign ram_wr_valid_o = push;
    assign ram_wr_addr_o  = wr_ptr_q[addr_w_lp-1:0];
    assign ram_wr_data_o  = data_i;
    assign ram_rd_addr_o  = rd_ptr_q[addr_w_lp-1:0];
    assign data_o         = ram_rd_data_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            // Catching the read pointer up discards every stored word.
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + ptr_one_lp;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + ptr_one_lp;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: tb/tb_fifo_ctrl_1r1w.sv
// tb/tb_fifo_ctrl_1r1w.sv - randomized and directed bench for fifo_ctrl_1r1w against a queue model

module tb_fifo_ctrl_1r1w;

    localparam int W = 8;
    localparam int D = 8;
    localparam int AW = $clog2(D);

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b1;
    logic          flush_i = 1'b0;
    logic          valid_i = 1'b0;
    logic [W-1:0]  data_i = '0;
    logic          ready_o;
    logic          valid_o;
    logic [W-1:0]  data_o;
    logic          ready_i = 1'b0;
    logic [AW:0]   count_o;
    logic          ram_wr_valid_o;
    logic [AW-1:0] ram_wr_addr_o;
    logic [W-1:0]  ram_wr_data_o;
    logic [AW-1:0] ram_rd_addr_o;
    logic [W-1:0]  ram_rd_data_i;

    logic [W-1:0]  ram [D];

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] model_q [$];
    bit           model_known = 0;

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (ram_wr_valid_o) ram[ram_wr_addr_o] <= ram_wr_data_o;
    end
    assign ram_rd_data_i = ram[ram_rd_addr_o];

    fifo_ctrl_1r1w #(.width_p(W), .depth_p(D)) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .flush_i        (flush_i),
        .valid_i        (valid_i),
        .data_i         (data_i),
        .ready_o        (ready_o),
        .valid_o        (valid_o),
        .data_o         (data_o),
        .ready_i        (ready_i),
        .count_o        (count_o),
        .ram_wr_valid_o (ram_wr_valid_o),
        .ram_wr_addr_o  (ram_wr_addr_o),
        .ram_wr_data_o  (ram_wr_data_o),
        .ram_rd_addr_o  (ram_rd_addr_o),
        .ram_rd_data_i  (ram_rd_data_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, compare pre-edge outputs with the model,
    // then advance the model by the queue rules and leave time 1 after the edge.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic r,
                         input logic f, input logic rst);
        bit exp_push;
        bit exp_pop;
        valid_i = v;
        data_i  = d;
        ready_i = r;
        flush_i = f;
        reset_i = rst;
        #2;
        exp_push = model_known && v && (model_q.size() < D) && !rst && !f;
        exp_pop  = model_known && r && (model_q.size() > 0) && !rst && !f;
        if (model_known) begin
            check("valid_o", {31'd0, valid_o}, {31'd0, model_q.size() > 0});
            check("ready_o", {31'd0, ready_o}, {31'd0, model_q.size() < D});
            check("count_o", 32'(count_o), 32'(model_q.size()));
            if (model_q.size() > 0) check("data_o", 32'(data_o), 32'(model_q[0]));
        end
        if (rst) check("wr_in_reset", {31'd0, ram_wr_valid_o}, 32'd0);
        else if (model_known) check("ram_wr_valid", {31'd0, ram_wr_valid_o}, {31'd0, exp_push});
        @(posedge clk_i);
        if (rst || f) begin
            model_q.delete();
            if (rst) model_known = 1;
        end else begin
            if (exp_pop) void'(model_q.pop_front());
            if (exp_push) model_q.push_back(d);
        end
        #1;
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] pend_d;
        bit           pend_v;
        int           p_valid;
        int           p_ready;

        @(posedge clk_i);
        #1;

        // Reset held two cycles with a producer asserting valid.
        cycle(1, 8'h55, 0, 0, 1);
        cycle(1, 8'h55, 0, 0, 1);
        valid_i = 0;
        reset_i = 0;
        #1;
        check("rst_count", 32'(count_o), 32'd0);
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_ready", {31'd0, ready_o}, 32'd1);

        // Fill to capacity, then a rejected ninth word, then drain in order.
        for (int i = 1; i <= D; i++) begin
            cycle(1, W'(i), 0, 0, 0);
            check("fill_count", 32'(count_o), 32'(i));
        end
        check("fill_ready", {31'd0, ready_o}, 32'd0);
        cycle(1, 8'h09, 0, 0, 0);
        check("fill_reject", 32'(count_o), 32'(D));
        for (int i = 1; i <= D; i++) begin
            check("drain_data", 32'(data_o), 32'(i));
            cycle(0, 8'h00, 1, 0, 0);
        end
        check("drain_empty", {31'd0, valid_o}, 32'd0);

        // Prime three entries, then lockstep push/pop across the wrap.
        for (int i = 0; i < 3; i++) cycle(1, W'(8'h40 + i), 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            check("wrap_head", 32'(data_o), 32'(8'h40 + i));
            cycle(1, W'(8'h43 + i), 1, 0, 0);
            check("wrap_count", 32'(count_o), 32'd3);
        end
        for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1, 0, 0);

        // Full with simultaneous pop and push attempt: only the pop happens.
        for (int i = 0; i < D; i++) cycle(1, W'(8'h80 + i), 0, 0, 0);
        check("full_count", 32'(count_o), 32'(D));
        valid_i = 1;
        ready_i = 1;
        #1;
        check("full_pop_ready", {31'd0, ready_o}, 32'd0);
        cycle(1, 8'hEE, 1, 0, 0);
        check("full_pop_count", 32'(count_o), 32'(D - 1));
        check("full_pop_ready_next", {31'd0, ready_o}, 32'd1);
        while (model_q.size() > 0) cycle(0, 8'h00, 1, 0, 0);

        // Empty plus push: valid rises only on the following cycle.
        valid_i = 1;
        data_i  = 8'hA5;
        ready_i = 1;
        #1;
        check("empty_push_valid", {31'd0, valid_o}, 32'd0);
        cycle(1, 8'hA5, 1, 0, 0);
        check("empty_push_valid_next", {31'd0, valid_o}, 32'd1);
        check("empty_push_data", 32'(data_o), 32'hA5);
        cycle(0, 8'h00, 1, 0, 0);

        // Flush with five entries while both sides request a transfer.
        for (int i = 0; i < 5; i++) cycle(1, W'(8'h20 + i), 0, 0, 0);
        valid_i = 1;
        ready_i = 1;
        flush_i = 1;
        data_i  = 8'h77;
        #1;
        check("flush_no_write", {31'd0, ram_wr_valid_o}, 32'd0);
        cycle(1, 8'h77, 1, 1, 0);
        check("flush_count", 32'(count_o), 32'd0);
        check("flush_valid", {31'd0, valid_o}, 32'd0);
        cycle(1, 8'h3C, 0, 0, 0);
        check("flush_repush", 32'(data_o), 32'h3C);
        cycle(0, 8'h00, 1, 0, 0);

        // Randomized traffic with phase-varying pressure, rare flush and reset.
        pend_v = 0;
        pend_d = '0;
        for (int n = 0; n < 3000; n++) begin
            bit v;
            bit r;
            bit f;
            bit rs;
            bit pushed;
            if (n % 200 == 0) begin
                p_valid = $urandom_range(20, 90);
                p_ready = $urandom_range(20, 90);
            end
            if (pend_v) begin
                v = 1;
            end else begin
                v = ($urandom_range(0, 99) < p_valid);
                pend_d = W'($urandom);
            end
            r  = ($urandom_range(0, 99) < p_ready);
            f  = ($urandom_range(0, 99) < 2);
            rs = ($urandom_range(0, 199) < 1);
            pushed = v && !f && !rs && (model_q.size() < D);
            cycle(v, pend_d, r, f, rs);
            pend_v = v && !pushed && !f && !rs;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
